fft_packetizer: RTL and testbench

Framing stage between the FFT processor and the UDP/IP stack. It collects consecutive FFT bins into fixed-size packets and compresses each complex bin to one 32-bit word. It prepends a two-word header carrying the sequence, frame and bin position, then streams packets over a valid/ready interface. Two packet buffers (ping-pong) absorb back-pressure from the network side.

---
 rtl/fft_packetizer.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_fft_packetizer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_packetizer.sv
// Packs FFT bins into ping-pong packet buffers and streams them with a two-word header.
// Define FFTPKT_ROUND_EN for round-half-up/saturate bin reduction (adds one write-path stage).
module fft_packetizer #(
    parameter int          FFT_SIZE     = 1024,
    parameter int          BINS_PER_PKT = 256,
    parameter logic [15:0] MAGIC        = 16'hF5D0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] fft_real,
    input  logic [23:0] fft_imag,
    input  logic        fft_valid,
    input  logic [10:0] fft_index,
    output logic [31:0] pkt_data,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic [15:0] pkt_len,
    output logic [15:0] drop_count,
    output logic        sync_error
);

    localparam int             AW        = $clog2(BINS_PER_PKT);
    localparam logic [10:0]    IDX_MASK  = 11'(FFT_SIZE - 1);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(BINS_PER_PKT - 1);

    typedef enum logic [1:0] {W_WAIT0, W_IDLE, W_FILL} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_HDR0, R_HDR1, R_PAYLOAD} rd_state_e;

    wr_state_e     wr_state_q, wr_state_d;
    logic          wr_sel_q, wr_sel_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [10:0]   prev_idx_q, prev_idx_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   drop_q, drop_d;
    logic          sync_q, sync_d;
    logic [1:0]    full_q, full_d;

    rd_state_e     rd_state_q, rd_state_d;
    logic          rd_sel_q, rd_sel_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [15:0]   seq_q, seq_d;
    logic          rd_last_hs;

    logic [10:0]   hdr_bin_q   [2];
    logic [15:0]   hdr_frame_q [2];
    logic [15:0]   hdr_frame_val;
    logic          hdr_we;

    logic          bin_ok, start_ok;
    logic [10:0]   next_idx;
    logic          wr_en, wr_done;
    logic [AW:0]   wr_addr;
    logic [31:0]   wr_word;

    logic          mem_we, mem_done;
    logic [AW:0]   mem_addr;
    logic [31:0]   mem_word;
    logic [31:0]   mem [2*BINS_PER_PKT];
    logic [31:0]   ram_q;

    assign pkt_len    = 16'((2 + BINS_PER_PKT) * 4);
    assign drop_count = drop_q;
    assign sync_error = sync_q;

`ifdef FFTPKT_ROUND_EN
    // Round half-up onto bits [23:8]: the 0x80 addend only carries in through bit 7.
    function automatic logic [15:0] round_sat(input logic [15:0] hi, input logic half);
        logic [16:0] s;
        s = {hi[15], hi} + {16'b0, half};
        return (s[16:15] == 2'b01) ? 16'h7FFF : s[15:0];
    endfunction

    logic [13:0] fract_unused;
    assign fract_unused = {fft_real[6:0], fft_imag[6:0]};
    assign wr_word = {round_sat(fft_real[23:8], fft_real[7]),
                      round_sat(fft_imag[23:8], fft_imag[7])};

    logic          wr_en_q, wr_done_q;
    logic [AW:0]   wr_addr_q;
    logic [31:0]   wr_word_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_done_q <= 1'b0;
            wr_addr_q <= '0;
            wr_word_q <= '0;
        end else begin
            wr_en_q   <= wr_en;
            wr_done_q <= wr_done;
            wr_addr_q <= wr_addr;
            wr_word_q <= wr_word;
        end
    end

    assign mem_we   = wr_en_q;
    assign mem_done = wr_done_q;
    assign mem_addr = wr_addr_q;
    assign mem_word = wr_word_q;
`else
    logic [15:0] fract_unused;
    assign fract_unused = {fft_real[7:0], fft_imag[7:0]};
    assign wr_word  = {fft_real[23:8], fft_imag[23:8]};
    assign mem_we   = wr_en;
    assign mem_done = wr_done;
    assign mem_addr = wr_addr;
    assign mem_word = wr_word;
`endif

    // Write side: alignment, overflow drop and index continuity.
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_sel_d      = wr_sel_q;
        wr_cnt_d      = wr_cnt_q;
        prev_idx_d    = prev_idx_q;
        frame_cnt_d   = frame_cnt_q;
        drop_d        = drop_q;
        sync_d        = 1'b0;
        wr_en         = 1'b0;
        wr_done       = 1'b0;
        hdr_we        = 1'b0;
        wr_addr       = {wr_sel_q, wr_cnt_q};
        bin_ok        = enable && fft_valid;
        next_idx      = (prev_idx_q + 11'd1) & IDX_MASK;
        hdr_frame_val = (fft_index == 11'd0) ? frame_cnt_q : frame_cnt_q - 16'd1;
        start_ok      = bin_ok && (fft_index[AW-1:0] == '0) &&
                        ((wr_state_q == W_IDLE) ||
                         ((wr_state_q == W_WAIT0) && (fft_index == 11'd0)));

        if (!enable) begin
            if (wr_state_q == W_FILL) begin
                wr_state_d = W_IDLE;
            end
        end else if (start_ok) begin
            if (full_q[wr_sel_q]) begin
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
                wr_state_d = W_IDLE;
            end else begin
                wr_en      = 1'b1;
                hdr_we     = 1'b1;
                wr_addr    = {wr_sel_q, {AW{1'b0}}};
                wr_cnt_d   = AW'(1);
                prev_idx_d = fft_index;
                wr_state_d = W_FILL;
                if (fft_index == 11'd0) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
        end else if (bin_ok && (wr_state_q == W_FILL)) begin
            if (fft_index == next_idx) begin
                wr_en      = 1'b1;
                prev_idx_d = fft_index;
                wr_cnt_d   = wr_cnt_q + AW'(1);
                if (wr_cnt_q == LAST_ADDR) begin
                    wr_done    = 1'b1;
                    wr_sel_d   = ~wr_sel_q;
                    wr_state_d = W_IDLE;
                end
            end else begin
                sync_d     = 1'b1;
                wr_state_d = W_WAIT0;
            end
        end
    end

    // Full flags never collide: writes only target a clear buffer, reads a full one.
    always_comb begin
        full_d = full_q;
        if (mem_done) begin
            full_d[mem_addr[AW]] = 1'b1;
        end
        if (rd_last_hs) begin
            full_d[rd_sel_q] = 1'b0;
        end
    end

    // Read side; rd_addr_d feeds the RAM so the next payload word is already registered.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_sel_d   = rd_sel_q;
        rd_addr_d  = rd_addr_q;
        seq_d      = seq_q;
        rd_last_hs = 1'b0;
        pkt_valid  = 1'b0;
        pkt_sop    = 1'b0;
        pkt_eop    = 1'b0;
        pkt_data   = '0;

        case (rd_state_q)
            R_IDLE: begin
                rd_addr_d = '0;
                if (full_q[rd_sel_q]) begin
                    rd_state_d = R_HDR0;
                end
            end
            R_HDR0: begin
                pkt_valid = 1'b1;
                pkt_sop   = 1'b1;
                pkt_data  = {MAGIC, seq_q};
                if (pkt_ready) begin
                    seq_d      = seq_q + 16'd1;
                    rd_state_d = R_HDR1;
                end
            end
            R_HDR1: begin
                pkt_valid = 1'b1;
                pkt_data  = {5'b0, hdr_bin_q[rd_sel_q], hdr_frame_q[rd_sel_q]};
                if (pkt_ready) begin
                    rd_state_d = R_PAYLOAD;
                end
            end
            R_PAYLOAD: begin
                pkt_valid = 1'b1;
                pkt_data  = ram_q;
                pkt_eop   = (rd_addr_q == LAST_ADDR);
                if (pkt_ready) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_last_hs = 1'b1;
                        rd_sel_d   = ~rd_sel_q;
                        rd_addr_d  = '0;
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q  <= W_WAIT0;
            wr_sel_q    <= 1'b0;
            wr_cnt_q    <= '0;
            prev_idx_q  <= '0;
            frame_cnt_q <= '0;
            drop_q      <= '0;
            sync_q      <= 1'b0;
            full_q      <= '0;
            rd_state_q  <= R_IDLE;
            rd_sel_q    <= 1'b0;
            rd_addr_q   <= '0;
            seq_q       <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_sel_q    <= wr_sel_d;
            wr_cnt_q    <= wr_cnt_d;
            prev_idx_q  <= prev_idx_d;
            frame_cnt_q <= frame_cnt_d;
            drop_q      <= drop_d;
            sync_q      <= sync_d;
            full_q      <= full_d;
            rd_state_q  <= rd_state_d;
            rd_sel_q    <= rd_sel_d;
            rd_addr_q   <= rd_addr_d;
            seq_q       <= seq_d;
        end
    end

    // Header fields are kept per buffer because the reader lags the writer by a packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_bin_q[0]   <= '0;
            hdr_bin_q[1]   <= '0;
            hdr_frame_q[0] <= '0;
            hdr_frame_q[1] <= '0;
        end else if (hdr_we) begin
            hdr_bin_q[wr_sel_q]   <= fft_index;
            hdr_frame_q[wr_sel_q] <= hdr_frame_val;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_word;
        end
        ram_q <= mem[{rd_sel_d, rd_addr_d}];
    end

endmodule

// File: tb/tb_fft_packetizer.sv
// Scoreboard bench for fft_packetizer: expected packet words are queued as bins are driven.
module tb_fft_packetizer;

    localparam int          BPP   = 256;
    localparam logic [15:0] MAGIC = 16'hF5D0;
`ifdef FFTPKT_ROUND_EN
    localparam int HDR_LAT = 3;
`else
    localparam int HDR_LAT = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [23:0] fft_real;
    logic [23:0] fft_imag;
    logic        fft_valid;
    logic [10:0] fft_index;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [15:0] pkt_len;
    logic [15:0] drop_count;
    logic        sync_error;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t        expQ[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          readyMode   = 1;
    int          syncHigh    = 0;
    int          wordsInPkt  = 0;
    logic [15:0] expSeq      = 16'd0;
    logic        stallPrev   = 1'b0;
    logic [31:0] prevData;
    logic        prevSop;
    logic        prevEop;

    fft_packetizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fft_real   (fft_real),
        .fft_imag   (fft_imag),
        .fft_valid  (fft_valid),
        .fft_index  (fft_index),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_sop    (pkt_sop),
        .pkt_eop    (pkt_eop),
        .pkt_len    (pkt_len),
        .drop_count (drop_count),
        .sync_error (sync_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ready is either held or toggled randomly, changing just after each rising edge.
    initial begin
        pkt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       pkt_ready = 1'b0;
                1:       pkt_ready = 1'b1;
                default: pkt_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [23:0] binReal(input int idx, input int salt);
        logic [10:0] i;
        i = 11'(idx);
        if (salt == 0) return 24'h012345;
        if (salt == 3) begin
            case (idx % 4)
                0: return 24'h7FFF80;
                1: return 24'h000180;
                2: return 24'h800000;
                default: ;
            endcase
        end
        return {5'(salt), i, i[7:0]};
    endfunction

    function automatic logic [23:0] binImag(input int idx, input int salt);
        logic [10:0] i;
        i = 11'(idx);
        if (salt == 0) return 24'hFFFF00;
        return {~i[7:0], 5'(salt), i};
    endfunction

    function automatic logic [15:0] reduceModel(input logic [23:0] x);
`ifdef FFTPKT_ROUND_EN
        int v;
        v = int'($signed(x));
        v = (v + 128) >>> 8;
        if (v > 32767) v = 32767;
        return v[15:0];
`else
        return x[23:8];
`endif
    endfunction

    task automatic expectPacket(input int startBin, input logic [15:0] frame, input int salt);
        exp_t e;
        e.data = {MAGIC, expSeq};
        e.sop  = 1'b1;
        e.eop  = 1'b0;
        expQ.push_back(e);
        expSeq = expSeq + 16'd1;
        e.data = {5'b0, 11'(startBin), frame};
        e.sop  = 1'b0;
        expQ.push_back(e);
        for (int k = 0; k < BPP; k++) begin
            e.data = {reduceModel(binReal(startBin + k, salt)), reduceModel(binImag(startBin + k, salt))};
            e.eop  = (k == BPP - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input int firstIdx, input int lastIdx, input int gap, input int salt);
        for (int idx = firstIdx; idx <= lastIdx; idx++) begin
            @(posedge clk);
            #1;
            fft_valid = 1'b1;
            fft_index = 11'(idx);
            fft_real  = binReal(idx, salt);
            fft_imag  = binImag(idx, salt);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                fft_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        fft_valid = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        int n;
        n = 0;
        while ((expQ.size() != 0 || pkt_valid) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainLeft", 32'(expQ.size()), 32'd0);
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Output monitor: handshake words against the scoreboard, and hold-during-stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("stallValid", 32'(pkt_valid), 32'd1);
                checkOutput("stallData", pkt_data, prevData);
                checkOutput("stallSop", 32'(pkt_sop), 32'(prevSop));
                checkOutput("stallEop", 32'(pkt_eop), 32'(prevEop));
            end
            if (sync_error) syncHigh++;
            if (pkt_valid && pkt_ready) begin
                checkOutput("sbNonEmpty", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("pktData", pkt_data, e.data);
                    checkOutput("pktSop", 32'(pkt_sop), 32'(e.sop));
                    checkOutput("pktEop", 32'(pkt_eop), 32'(e.eop));
                end
                wordsInPkt = pkt_sop ? 1 : wordsInPkt + 1;
            end
            stallPrev = pkt_valid && !pkt_ready;
            prevData  = pkt_data;
            prevSop   = pkt_sop;
            prevEop   = pkt_eop;
        end
    end

    initial begin
        int lat;
        int n;
        rst_n     = 1'b0;
        enable    = 1'b0;
        fft_valid = 1'b0;
        fft_index = '0;
        fft_real  = '0;
        fft_imag  = '0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rstValid", 32'(pkt_valid), 32'd0);
        checkOutput("rstSop", 32'(pkt_sop), 32'd0);
        checkOutput("rstEop", 32'(pkt_eop), 32'd0);
        checkOutput("rstData", pkt_data, 32'd0);
        checkOutput("rstDrop", 32'(drop_count), 32'd0);
        checkOutput("rstSync", 32'(sync_error), 32'd0);
        checkOutput("pktLen", 32'(pkt_len), 32'((2 + BPP) * 4));
        rst_n  = 1'b1;
        enable = 1'b1;

        $display("[TB] basic packet");
        expectPacket(0, 16'd0, 0);
        applyStimulus(0, 255, 0, 0);
        lat = 1;
        while (!pkt_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("hdrLatency", 32'(lat), 32'(HDR_LAT));
        waitDrain(2000);
        checkOutput("basicDrop", 32'(drop_count), 32'd0);

        $display("[TB] full frame with random back-pressure");
        readyMode = 2;
        for (int p = 0; p < 4; p++) expectPacket(p * BPP, 16'd1, 5);
        applyStimulus(0, 1023, 3, 5);
        waitDrain(20000);
        readyMode = 1;
        checkOutput("frameDrop", 32'(drop_count), 32'd0);

        $display("[TB] overflow");
        readyMode = 0;
        repeat (3) @(posedge clk);
        expectPacket(0, 16'd2, 7);
        expectPacket(256, 16'd2, 7);
        applyStimulus(0, 767, 0, 7);
        checkOutput("ovfDrop", 32'(drop_count), 32'd1);
        readyMode = 1;
        waitDrain(3000);

        $display("[TB] sync error");
        syncHigh = 0;
        applyStimulus(0, 10, 0, 9);
        applyStimulus(12, 255, 0, 9);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("syncPulse", 32'(syncHigh), 32'd1);
        checkOutput("syncNoPkt", 32'(pkt_valid), 32'd0);
        expectPacket(0, 16'd4, 13);
        applyStimulus(0, 255, 0, 13);
        waitDrain(2000);
        checkOutput("syncDrop", 32'(drop_count), 32'd1);

        $display("[TB] enable low abandons partial packet");
        applyStimulus(0, 99, 0, 15);
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b1;
        expectPacket(256, 16'd5, 3);
        applyStimulus(256, 511, 0, 3);
        waitDrain(2000);
        checkOutput("enDrop", 32'(drop_count), 32'd1);
        checkOutput("enSync", 32'(syncHigh), 32'd1);

        $display("[TB] reset mid-packet");
        expectPacket(0, 16'd6, 5);
        applyStimulus(0, 255, 0, 5);
        n = 0;
        while (wordsInPkt != 101 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rstWait", 32'(wordsInPkt), 32'd101);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midRstValid", 32'(pkt_valid), 32'd0);
        checkOutput("midRstEop", 32'(pkt_eop), 32'd0);
        checkOutput("midRstDrop", 32'(drop_count), 32'd0);
        expQ.delete();
        expSeq = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expectPacket(0, 16'd0, 11);
        applyStimulus(0, 255, 0, 11);
        waitDrain(2000);
        checkOutput("postRstDrop", 32'(drop_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
